// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO with storage, pointer control and status in one block.
// Occupancy is tracked by an explicit counter; the pointers are only used
// for addressing and are never compared with each other.
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   DEPTH       number of entries (power of two, >= 2)
//   AF_THRESH   ALMOST_FULL  when occupancy >= AF_THRESH (1..DEPTH)
//   AE_THRESH   ALMOST_EMPTY when occupancy <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   CLK           clock, everything on the rising edge
//   RST           synchronous active-low reset
//   WR_EN/WR_DATA write request and data
//   RD_EN         read request
//   RD_DATA       registered read data, holds when no read is accepted
//   RD_VALID      one-cycle strobe, RD_DATA was loaded at the last edge
//   FULL/EMPTY    occupancy == DEPTH / occupancy == 0
//   ALMOST_FULL   occupancy >= AF_THRESH
//   ALMOST_EMPTY  occupancy <= AE_THRESH
//   COUNT         occupancy 0..DEPTH
//   OVERFLOW      sticky, a write was dropped
//   UNDERFLOW     sticky, a read was dropped
//   CLR_ERR       clears OVERFLOW/UNDERFLOW (a same-cycle set wins)
//
// All outputs come straight from flops. Status flags are computed from the
// next occupancy so they change on the same edge as COUNT.
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    // Threshold constants sized to the occupancy counter.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ZERO_C  = (ADDR_WIDTH + 1)'(0);

    // Status decode helpers, shared by the next-state logic and the reset values.
    function automatic logic is_full(input logic [ADDR_WIDTH:0] cnt);
        return (cnt == DEPTH_C);
    endfunction

    function automatic logic is_empty(input logic [ADDR_WIDTH:0] cnt);
        return (cnt == ZERO_C);
    endfunction

    function automatic logic is_almost_full(input logic [ADDR_WIDTH:0] cnt);
        return (cnt >= AF_C);
    endfunction

    function automatic logic is_almost_empty(input logic [ADDR_WIDTH:0] cnt);
        return (cnt <= AE_C);
    endfunction

    // Storage: deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Accept decisions; a write into a full FIFO is allowed only when a read
    // frees a slot on the same edge.
    always_comb begin
        rd_acc_s  = RD_EN & ~empty_q;
        wr_acc_s  = WR_EN & (~full_q | rd_acc_s);
        rd_word_s = mem_array[rd_ptr_q];
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + (ADDR_WIDTH + 1)'(wr_acc_s) - (ADDR_WIDTH + 1)'(rd_acc_s);
    end

    // Read port next-state; data holds when nothing is read.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc_s;
        if (rd_acc_s) begin
            rd_data_d = rd_word_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Status flags from the next occupancy so they line up with COUNT.
    always_comb begin
        full_d         = is_full(count_d);
        empty_d        = is_empty(count_d);
        almost_full_d  = is_almost_full(count_d);
        almost_empty_d = is_almost_empty(count_d);
    end

    // Sticky error flags; a new error beats a clear on the same edge.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (WR_EN & ~wr_acc_s) begin
            overflow_d = 1'b1;
        end else if (CLR_ERR) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (RD_EN & empty_q) begin
            underflow_d = 1'b1;
        end else if (CLR_ERR) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= ZERO_C;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            full_q         <= is_full(ZERO_C);
            empty_q        <= is_empty(ZERO_C);
            almost_full_q  <= is_almost_full(ZERO_C);
            almost_empty_q <= is_almost_empty(ZERO_C);
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage write; suppressed while reset is asserted.
    always_ff @(posedge CLK) begin
        if (RST && wr_acc_s) begin
            mem_array[wr_ptr_q] <= WR_DATA;
        end
    end

    assign RD_DATA      = rd_data_q;
    assign RD_VALID     = rd_valid_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = almost_full_q;
    assign ALMOST_EMPTY = almost_empty_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl. Two instances share stimulus: A uses the
// default thresholds (6/2), B uses AF=7/AE=0. A queue-based model of the
// FIFO predicts every output; a negedge process compares both instances.
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          CLK;
    logic          RST;
    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic          RD_EN;
    logic          CLR_ERR;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          full_a, full_b, empty_a, empty_b;
    logic          af_a, af_b, ae_a, ae_b;
    logic [3:0]    count_a, count_b;
    logic          ovf_a, ovf_b, udf_a, udf_b;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(2)) dut_a (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(rd_data_a), .RD_VALID(rd_valid_a), .FULL(full_a), .EMPTY(empty_a),
        .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a), .COUNT(count_a),
        .OVERFLOW(ovf_a), .UNDERFLOW(udf_a), .CLR_ERR(CLR_ERR)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(7), .AE_THRESH(0)) dut_b (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b), .FULL(full_b), .EMPTY(empty_b),
        .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b), .COUNT(count_b),
        .OVERFLOW(ovf_b), .UNDERFLOW(udf_b), .CLR_ERR(CLR_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update for one rising edge, from the spec's rules on a queue.
    task automatic model_edge();
        bit racc, wacc, full, empty;
        if (!RST) begin
            mq.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
        end else begin
            full  = (mq.size() == DP);
            empty = (mq.size() == 0);
            racc  = RD_EN && !empty;
            wacc  = WR_EN && (!full || racc);
            if (racc) begin
                m_rd_data  = mq.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (wacc) mq.push_back(WR_DATA);
            if (WR_EN && !wacc) m_ovf = 1'b1;
            else if (CLR_ERR)   m_ovf = 1'b0;
            if (RD_EN && empty) m_udf = 1'b1;
            else if (CLR_ERR)   m_udf = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, return at negedge.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic clr, input logic rst_n);
        WR_EN   = wr;
        WR_DATA = d;
        RD_EN   = rd;
        CLR_ERR = clr;
        RST     = rst_n;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // Compare both instances against the model on every cycle.
    always @(negedge CLK) begin
        if (check_en) begin
            cmp("count_a",  32'(count_a),    32'(mq.size()));
            cmp("full_a",   32'(full_a),     32'(mq.size() == DP));
            cmp("empty_a",  32'(empty_a),    32'(mq.size() == 0));
            cmp("af_a",     32'(af_a),       32'(mq.size() >= 6));
            cmp("ae_a",     32'(ae_a),       32'(mq.size() <= 2));
            cmp("rvalid_a", 32'(rd_valid_a), 32'(m_rd_valid));
            cmp("rdata_a",  32'(rd_data_a),  32'(m_rd_data));
            cmp("ovf_a",    32'(ovf_a),      32'(m_ovf));
            cmp("udf_a",    32'(udf_a),      32'(m_udf));
            cmp("count_b",  32'(count_b),    32'(mq.size()));
            cmp("af_b",     32'(af_b),       32'(mq.size() >= 7));
            cmp("ae_b",     32'(ae_b),       32'(mq.size() == 0));
            cmp("rvalid_b", 32'(rd_valid_b), 32'(m_rd_valid));
            cmp("rdata_b",  32'(rd_data_b),  32'(m_rd_data));
        end
    end

    initial begin
        logic [DW-1:0] v;
        WR_EN = 1'b0; WR_DATA = '0; RD_EN = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
        m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge CLK);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        // Reset state, hand-computed
        cmp("rst_count", 32'(count_a), 32'd0);
        cmp("rst_empty", 32'(empty_a), 32'd1);
        cmp("rst_ae",    32'(ae_a),    32'd1);
        cmp("rst_af",    32'(af_a),    32'd0);
        cmp("rst_rdata", 32'(rd_data_a), 32'd0);

        // 1: fill with 0x11..0x88, then drain in order
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 17);
            step(1'b1, v, 1'b0, 1'b0, 1'b1);
            cmp("t1_af", 32'(af_a), 32'(i >= 6));
        end
        cmp("t1_count", 32'(count_a), 32'd8);
        cmp("t1_full",  32'(full_a),  32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            cmp("t1_rvalid", 32'(rd_valid_a), 32'd1);
            cmp("t1_rdata",  32'(rd_data_a),  32'(i * 17));
        end
        cmp("t1_empty", 32'(empty_a), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cmp("t1_strobe", 32'(rd_valid_a), 32'd0);

        // 2: overflow on a full FIFO, full write+read, set-wins, clear
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 17);
            step(1'b1, v, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        cmp("t2_ovf",   32'(ovf_a),   32'd1);
        cmp("t2_count", 32'(count_a), 32'd8);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        cmp("t2_rdata", 32'(rd_data_a), 32'h11);
        cmp("t2_count2", 32'(count_a),  32'd8);
        cmp("t2_ovf2",  32'(ovf_a),     32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        cmp("t2_setwins", 32'(ovf_a), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cmp("t2_clr", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cmp("t2_last", 32'(rd_data_a), 32'h99);

        // 3: read and write on an empty FIFO
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        cmp("t3_udf",    32'(udf_a),      32'd1);
        cmp("t3_rvalid", 32'(rd_valid_a), 32'd0);
        cmp("t3_count",  32'(count_a),    32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cmp("t3_rdata",  32'(rd_data_a),  32'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cmp("t3_clr", 32'(udf_a), 32'd0);

        // 4: stream 20 pairs with 3 entries resident
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(k + 3), 1'b1, 1'b0, 1'b1);
            cmp("t4_rdata", 32'(rd_data_a), 32'(k));
            cmp("t4_count", 32'(count_a),   32'd3);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cmp("t4_ovf", 32'(ovf_a), 32'd0);
        cmp("t4_udf", 32'(udf_a), 32'd0);

        // 5: reset with 5 entries and a read on the reset edge
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        cmp("t5_count",  32'(count_a),    32'd0);
        cmp("t5_empty",  32'(empty_a),    32'd1);
        cmp("t5_rvalid", 32'(rd_valid_a), 32'd0);
        cmp("t5_rdata",  32'(rd_data_a),  32'd0);
        step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cmp("t5_new", 32'(rd_data_a), 32'h5C);

        // 6: threshold sweep on instance B
        cmp("t6_ae0", 32'(ae_b), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            cmp("t6_af_up", 32'(af_b), 32'(i >= 7));
            cmp("t6_ae_up", 32'(ae_b), 32'd0);
        end
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            cmp("t6_af_dn", 32'(af_b), 32'(i >= 7));
            cmp("t6_ae_dn", 32'(ae_b), 32'(i == 0));
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 79) != 0));
        end

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
